// File: rtl/cdb_pkg.sv
// Shared CDB types and constants.
// Tag encodings and source indices.
package cdb_pkg;

  localparam int N_SRC  = 6;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 3;

  localparam logic [TAG_W-1:0] TAG_NONE    = 4'd0;
  localparam logic [TAG_W-1:0] TAG_LS_BASE = 4'd1;
  localparam logic [TAG_W-1:0] TAG_ADD1    = 4'd7;
  localparam logic [TAG_W-1:0] TAG_ADD2    = 4'd8;
  localparam logic [TAG_W-1:0] TAG_ADD3    = 4'd9;
  localparam logic [TAG_W-1:0] TAG_MULT1   = 4'd10;
  localparam logic [TAG_W-1:0] TAG_MULT2   = 4'd11;

  localparam logic [SRC_W-1:0] SRC_LS    = 3'd0;
  localparam logic [SRC_W-1:0] SRC_ADD1  = 3'd1;
  localparam logic [SRC_W-1:0] SRC_ADD2  = 3'd2;
  localparam logic [SRC_W-1:0] SRC_ADD3  = 3'd3;
  localparam logic [SRC_W-1:0] SRC_MULT1 = 3'd4;
  localparam logic [SRC_W-1:0] SRC_MULT2 = 3'd5;

  // Pointer advance with wrap at n-1.
  function automatic logic [SRC_W-1:0] next_ptr(
    input logic [SRC_W-1:0] i,
    input int               n
  );
    return (int'(i) == n - 1) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin priority picker.
// Scans from ptr upward, wrapping at N.
module rr_pick #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  // First request at or after ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: per-unit holding regs, RR broadcast.
// Optional CDB_PERF_EN adds busy/conflict counters.
module cdb_arbiter #(
  parameter int N_SRC  = 6,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*TAG_W-1:0]  src_tag,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [2:0]              cdb_src
`ifdef CDB_PERF_EN
  ,
  output logic [31:0]             perf_busy_cnt,
  output logic [31:0]             perf_conflict_cnt
`endif
);

  import cdb_pkg::*;

  logic [N_SRC-1:0]  hold_vld_q, hold_vld_d;
  logic [TAG_W-1:0]  hold_tag_q  [N_SRC];
  logic [TAG_W-1:0]  hold_tag_d  [N_SRC];
  logic [DATA_W-1:0] hold_data_q [N_SRC];
  logic [DATA_W-1:0] hold_data_d [N_SRC];

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [2:0]        cdb_src_q, cdb_src_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;

  logic [N_SRC-1:0]  gnt;
  logic [2:0]        gnt_idx;
  logic              gnt_any;

  rr_pick #(
    .N (N_SRC),
    .W (3)
  ) u_pick (
    .req (hold_vld_q),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // A slot accepts when empty or draining this cycle.
  always_comb begin
    src_ready = flush ? '0 : (~hold_vld_q | gnt);
  end

  // Holding regs, broadcast reg and pointer next-state.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_tag_d  = hold_tag_q;
    hold_data_d = hold_data_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush) begin
      hold_vld_d = '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          hold_vld_d[i]  = 1'b1;
          hold_tag_d[i]  = src_tag[i*TAG_W +: TAG_W];
          hold_data_d[i] = src_data[i*DATA_W +: DATA_W];
        end else if (gnt[i]) begin
          hold_vld_d[i] = 1'b0;
        end
      end
      if (gnt_any) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = hold_tag_q[gnt_idx];
        cdb_data_d  = hold_data_q[gnt_idx];
        cdb_src_d   = gnt_idx;
        rr_ptr_d    = next_ptr(gnt_idx, N_SRC);
      end
    end
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_vld_q  <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        hold_tag_q[i]  <= '0;
        hold_data_q[i] <= '0;
      end
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_tag_q  <= hold_tag_d;
      hold_data_q <= hold_data_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

`ifdef CDB_PERF_EN
  logic [31:0] busy_q, busy_d;
  logic [31:0] conf_q, conf_d;
  logic        multi;

  // Saturating counters; flush leaves them alone.
  always_comb begin
    multi  = |(hold_vld_q & (hold_vld_q - 1'b1));
    busy_d = busy_q;
    conf_d = conf_q;
    if (cdb_valid_q && (busy_q != '1)) busy_d = busy_q + 1'b1;
    if (multi && (conf_q != '1))       conf_d = conf_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      conf_q <= '0;
    end else begin
      busy_q <= busy_d;
      conf_q <= conf_d;
    end
  end

  assign perf_busy_cnt     = busy_q;
  assign perf_conflict_cnt = conf_q;
`endif

endmodule
